// File: rtl/apu_host_pkg.sv
// Shared definitions for the APU host sequencer: target address map, size limits,
// FSM state encoding and the RAM word-to-byte address helper.
package apu_host_pkg;

   localparam logic [13:0] RAM_CTRL_ADDR  = 14'h2000;
   localparam logic [13:0] RAM_SEL_ADDR   = 14'h2004;
   localparam logic [13:0] APU_READY_ADDR = 14'h2008;
   localparam logic [13:0] CPL_ADDR       = 14'h200C;
   localparam int          MAX_WORDS      = 2048;

   typedef enum logic [3:0] {
      IDLE,
      CLR,
      WR_SEL,
      WR_CTRL,
      LOAD,
      KICK,
      WAIT_INT,
      RD_CPL,
      CHK_CPL,
      UNLOAD,
      FIN
   } state_t;

   function automatic logic [12:0] word_byte_addr(input logic [10:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/apu_host_rdbuf.sv
// Two-entry 32-bit FIFO that holds unload read data until the result stream accepts it.
module apu_host_rdbuf (
   input  logic        clk,
   input  logic        rstn,
   input  logic        push,
   input  logic [31:0] push_data,
   input  logic        pop,
   output logic [31:0] head,
   output logic [1:0]  count
);

   logic [31:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/apu_host_seq.sv
// Host-side bus initiator running a full APU job: load RAM, program, kick, wait, unload.
// Optional watchdog on the completion wait is enabled by defining APU_HOST_TIMEOUT_EN.
module apu_host_seq
   import apu_host_pkg::*;
#(
   parameter int T_ADDR_WID = 14,
   parameter int LEN_WID    = 12,
   parameter int TMO_WID    = 20
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [7:0]            cfg_sel,
   input  logic [1:0]            cfg_ctrl,
   input  logic [LEN_WID-1:0]    cfg_wr_len,
   input  logic [LEN_WID-1:0]    cfg_rd_len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [31:0]           s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_data,
   output logic [T_ADDR_WID-1:0] t_waddr,
   output logic [T_ADDR_WID-1:0] t_raddr,
   output logic                  t_wren,
   output logic                  t_rden,
   output logic [31:0]           t_wdata,
   input  logic [31:0]           t_rdata,
   input  logic                  int_cal
);

   localparam logic [LEN_WID:0] MAX_LEN = (LEN_WID+1)'(MAX_WORDS);

   state_t           state;
   state_t           nxt;
   logic [7:0]       sel_q;
   logic [1:0]       ctrl_q;
   logic [LEN_WID:0] wr_len_q;
   logic [LEN_WID:0] rd_len_q;
   logic [LEN_WID:0] idx;
   logic [LEN_WID:0] idx_inc;
   logic             pend;
   logic             len_bad;
   logic             err_set;
   logic             err_clr;
   logic             buf_pop;
   logic [1:0]       buf_cnt;
   logic [31:0]      buf_head;
   logic [2:0]       occ;

   assign idx_inc = idx + 1'b1;
   assign len_bad = ({1'b0, cfg_wr_len} > MAX_LEN) || ({1'b0, cfg_rd_len} > MAX_LEN);
   assign occ     = 3'(buf_cnt) + 3'(pend) - 3'(buf_pop);

`ifdef APU_HOST_TIMEOUT_EN
   logic [TMO_WID-1:0] tmo_cnt;
   logic               tmo_hit;

   assign tmo_hit = &tmo_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt <= '0;
      end else if (state != WAIT_INT) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt     = state;
      t_wren  = 1'b0;
      t_rden  = 1'b0;
      t_waddr = '0;
      t_raddr = '0;
      t_wdata = '0;
      s_ready = 1'b0;
      done    = 1'b0;
      err_set = 1'b0;
      err_clr = 1'b0;
      buf_pop = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len_bad) begin
                  err_set = 1'b1;
                  nxt     = FIN;
               end else begin
                  err_clr = 1'b1;
                  nxt     = int_cal ? CLR : WR_SEL;
               end
            end
         end
         // err can only be set on entry here by the watchdog, so it selects the abort exit.
         CLR: begin
            t_rden  = 1'b1;
            t_raddr = T_ADDR_WID'(CPL_ADDR);
            nxt     = err ? FIN : WR_SEL;
         end
         WR_SEL: begin
            t_wren  = 1'b1;
            t_waddr = T_ADDR_WID'(RAM_SEL_ADDR);
            t_wdata = {24'b0, sel_q};
            nxt     = WR_CTRL;
         end
         WR_CTRL: begin
            t_wren  = 1'b1;
            t_waddr = T_ADDR_WID'(RAM_CTRL_ADDR);
            t_wdata = {30'b0, ctrl_q};
            nxt     = (wr_len_q == '0) ? KICK : LOAD;
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               t_wren  = 1'b1;
               t_waddr = T_ADDR_WID'(word_byte_addr(idx[10:0]));
               t_wdata = s_data;
               if (idx_inc == wr_len_q) begin
                  nxt = KICK;
               end
            end
         end
         KICK: begin
            t_wren  = 1'b1;
            t_waddr = T_ADDR_WID'(APU_READY_ADDR);
            t_wdata = 32'd1;
            nxt     = WAIT_INT;
         end
         WAIT_INT: begin
            if (int_cal) begin
               nxt = RD_CPL;
            end
`ifdef APU_HOST_TIMEOUT_EN
            else if (tmo_hit) begin
               err_set = 1'b1;
               nxt     = CLR;
            end
`endif
         end
         RD_CPL: begin
            t_rden  = 1'b1;
            t_raddr = T_ADDR_WID'(CPL_ADDR);
            nxt     = CHK_CPL;
         end
         CHK_CPL: begin
            if (t_rdata[0]) begin
               nxt = (rd_len_q == '0) ? FIN : UNLOAD;
            end else begin
               err_set = 1'b1;
               nxt     = FIN;
            end
         end
         // Credit the same-cycle pop so a ready consumer sees one word per cycle.
         UNLOAD: begin
            buf_pop = m_valid && m_ready;
            if ((idx != rd_len_q) && (occ < 3'd2)) begin
               t_rden  = 1'b1;
               t_raddr = T_ADDR_WID'(word_byte_addr(idx[10:0]));
            end
            if ((idx == rd_len_q) && !pend && (buf_cnt == 2'd0)) begin
               nxt = FIN;
            end
         end
         FIN: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_q    <= '0;
         ctrl_q   <= '0;
         wr_len_q <= '0;
         rd_len_q <= '0;
      end else if ((state == IDLE) && start) begin
         sel_q    <= cfg_sel;
         ctrl_q   <= cfg_ctrl;
         wr_len_q <= {1'b0, cfg_wr_len};
         rd_len_q <= {1'b0, cfg_rd_len};
      end
   end

   // One word index serves both the load writes and the unload read issues.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx  <= '0;
         pend <= 1'b0;
         err  <= 1'b0;
      end else begin
         if ((state != LOAD) && (state != UNLOAD)) begin
            idx <= '0;
         end else if (t_wren || t_rden) begin
            idx <= idx_inc;
         end
         pend <= (state == UNLOAD) && t_rden;
         if (err_clr) begin
            err <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   apu_host_rdbuf u_rdbuf (
      .clk       (clk),
      .rstn      (rstn),
      .push      (pend),
      .push_data (t_rdata),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_cnt)
   );

   assign m_valid = (buf_cnt != 2'd0);
   assign m_data  = buf_head;
   assign busy    = (state != IDLE) && (state != FIN);

endmodule

// File: tb/tb_apu_host_seq.sv
// Directed self-checking bench for apu_host_seq with a behavioural target-bus model.
// Timeout scenario runs only when APU_HOST_TIMEOUT_EN is defined.
module tb_apu_host_seq;

   typedef struct {
      bit          wr;
      logic [13:0] addr;
      logic [31:0] data;
      int          cyc;
   } bus_ev_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [7:0]  cfg_sel;
   logic [1:0]  cfg_ctrl;
   logic [11:0] cfg_wr_len;
   logic [11:0] cfg_rd_len;
   logic        busy, done, err;
   logic        s_valid, s_ready;
   logic [31:0] s_data;
   logic        m_valid, m_ready;
   logic [31:0] m_data;
   logic [13:0] t_waddr, t_raddr;
   logic        t_wren, t_rden;
   logic [31:0] t_wdata;
   logic [31:0] t_rdata = '0;
   logic        int_cal;

   int checks = 0;
   int failures = 0;

   bus_ev_t     log_q[$];
   logic [31:0] got_q[$];
   int          got_cyc[$];
   int cyc_n = 0, done_cnt = 0, kick_cnt = 0, cpl_cnt = 0, unl_rd = 0;
   int both_cnt = 0, stray_cnt = 0, max_ahead = 0;
   logic        rd_pend = 1'b0;
   logic [13:0] rd_addr = '0;
   logic [31:0] cpl_val = 32'd1;

   apu_host_seq #(.TMO_WID(8)) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_sel(cfg_sel), .cfg_ctrl(cfg_ctrl),
      .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len), .busy(busy), .done(done), .err(err),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .t_waddr(t_waddr), .t_raddr(t_raddr), .t_wren(t_wren), .t_rden(t_rden),
      .t_wdata(t_wdata), .t_rdata(t_rdata), .int_cal(int_cal)
   );

   always #5 clk = ~clk;

   // Bus monitor sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cyc_n++;
      if (done) done_cnt++;
      if (t_wren && t_rden) both_cnt++;
      if (!t_wren && ((t_waddr != '0) || (t_wdata != '0))) stray_cnt++;
      if (!t_rden && (t_raddr != '0)) stray_cnt++;
      if (t_wren) begin
         log_q.push_back('{1'b1, t_waddr, t_wdata, cyc_n});
         if (t_waddr == 14'h2008) kick_cnt++;
      end
      if (t_rden) begin
         log_q.push_back('{1'b0, t_raddr, 32'd0, cyc_n});
         if (t_raddr == 14'h200C) cpl_cnt++;
         else unl_rd++;
      end
      if (m_valid && m_ready) begin
         got_q.push_back(m_data);
         got_cyc.push_back(cyc_n);
      end
      if ((unl_rd - got_q.size()) > max_ahead) max_ahead = unl_rd - got_q.size();
      rd_pend <= t_rden;
      rd_addr <= t_raddr;
   end

   // Target read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (!rd_pend) t_rdata <= '0;
      else if (rd_addr == 14'h200C) t_rdata <= cpl_val;
      else t_rdata <= 32'hA0 + 32'(rd_addr[12:2]);
   end

   function automatic logic [31:0] in_word(input int k);
      return 32'hD000_0000 + 32'(k);
   endfunction

   task automatic start_job(input logic [7:0] sel, input logic [1:0] ctrl,
                            input logic [11:0] wl, input logic [11:0] rl);
      @(posedge clk); #1;
      cfg_sel = sel; cfg_ctrl = ctrl; cfg_wr_len = wl; cfg_rd_len = rl;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drives the input stream, interrupt and result-ready until done or budget expiry.
   task automatic serve(input int n_in, input int int_delay, input bit toggle_ready,
                        input int budget, output bit ok);
      int k = 0, cyc = 0, wait_c = 0;
      int kick0 = kick_cnt, cpl0 = cpl_cnt, dn0 = done_cnt;
      bit acc;
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      ok = 1'b0;
      s_valid = (n_in > 0);
      s_data  = in_word(0);
      m_ready = toggle_ready ? pat[0] : 1'b1;
      while (cyc < budget) begin
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            k++;
            s_data = in_word(k);
            if (k >= n_in) s_valid = 1'b0;
         end
         if (cpl_cnt != cpl0) begin
            int_cal = 1'b0;
            cpl0 = cpl_cnt;
         end
         if (kick_cnt != kick0) begin
            kick0 = kick_cnt;
            wait_c = int_delay;
            if (int_delay == 0) int_cal = 1'b1;
         end else if (wait_c > 0) begin
            wait_c--;
            if (wait_c == 0) int_cal = 1'b1;
         end
         m_ready = toggle_ready ? pat[cyc % 4] : 1'b1;
         if (done_cnt != dn0) begin
            ok = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; cfg_sel = 8'hAA; cfg_ctrl = 2'b01;
      cfg_wr_len = 12'd7; cfg_rd_len = 12'd7; s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
      m_ready = 1'b1; int_cal = 1'b0;
      #12;
      checks++; if ({busy, done, err, s_ready, m_valid, t_wren, t_rden} !== 7'b0) begin
         failures++; $display("[TB] FAIL reset_flags got=%b exp=0000000", {busy, done, err, s_ready, m_valid, t_wren, t_rden}); end
      checks++; if ({t_waddr, t_raddr, t_wdata, m_data} !== '0) begin
         failures++; $display("[TB] FAIL reset_data got=%h exp=0", {t_waddr, t_raddr, t_wdata, m_data}); end
      @(posedge clk); #1;
      rstn = 1'b1; s_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({busy, done, t_wren, t_rden} !== 4'b0) begin
         failures++; $display("[TB] FAIL idle_after_reset got=%b exp=0000", {busy, done, t_wren, t_rden}); end
   endtask

   task automatic test_load_job();
      logic [13:0] ea[8] = '{14'h2004, 14'h2000, 14'h0000, 14'h0004, 14'h0008, 14'h000C, 14'h2008, 14'h200C};
      logic [31:0] ed[8] = '{32'h5, 32'h3, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'h1, 32'h0};
      bit ew[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int base = log_q.size();
      int dn0 = done_cnt;
      bit ok;
      cpl_val = 32'd1;
      start_job(8'h05, 2'b11, 12'd4, 12'd0);
      cfg_sel = 8'hFF; cfg_ctrl = 2'b00; cfg_wr_len = 12'd9;
      serve(4, 10, 1'b0, 400, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL load_done got=timeout exp=done"); end
      checks++; if (log_q.size() - base != 8) begin
         failures++; $display("[TB] FAIL load_bus_count got=%0d exp=8", log_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ((log_q[base+i].wr !== ew[i]) || (log_q[base+i].addr !== ea[i]) ||
             (ew[i] && (log_q[base+i].data !== ed[i]))) begin
            failures++;
            $display("[TB] FAIL load_bus[%0d] got=%0b/%h/%h exp=%0b/%h/%h", i, log_q[base+i].wr,
                     log_q[base+i].addr, log_q[base+i].data, ew[i], ea[i], ed[i]);
         end
      end
      checks++; if (log_q[base+7].cyc - log_q[base+6].cyc < 11) begin
         failures++; $display("[TB] FAIL load_int_wait got=%0d exp>=11", log_q[base+7].cyc - log_q[base+6].cyc); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL load_err got=%b exp=0", err); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_cnt != dn0 + 1) begin
         failures++; $display("[TB] FAIL load_done_pulses got=%0d exp=1", done_cnt - dn0); end
   endtask

   task automatic test_unload_stream();
      int base = log_q.size();
      int gb = got_q.size();
      bit ok;
      start_job(8'h01, 2'b00, 12'd0, 12'd3);
      serve(0, 2, 1'b0, 200, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL unload_done got=timeout exp=done"); end
      checks++; if (log_q.size() - base != 7) begin
         failures++; $display("[TB] FAIL unload_bus_count got=%0d exp=7", log_q.size() - base); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ((log_q[base+4+i].wr !== 1'b0) || (log_q[base+4+i].addr !== 14'(4*i)) ||
             (log_q[base+4+i].cyc != log_q[base+4].cyc + i)) begin
            failures++;
            $display("[TB] FAIL unload_rd[%0d] got=%0b/%h/c%0d exp=0/%h/c%0d", i, log_q[base+4+i].wr,
                     log_q[base+4+i].addr, log_q[base+4+i].cyc, 14'(4*i), log_q[base+4].cyc + i);
         end
      end
      checks++; if (got_q.size() - gb != 3) begin
         failures++; $display("[TB] FAIL unload_words got=%0d exp=3", got_q.size() - gb); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ((got_q[gb+i] !== 32'hA0 + 32'(i)) || (got_cyc[gb+i] != got_cyc[gb] + i)) begin
            failures++;
            $display("[TB] FAIL unload_m_data[%0d] got=%h/c%0d exp=%h/c%0d", i, got_q[gb+i],
                     got_cyc[gb+i], 32'hA0 + 32'(i), got_cyc[gb] + i);
         end
      end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL unload_err got=%b exp=0", err); end
   endtask

   task automatic test_back_to_back();
      int gb = got_q.size();
      bit ok;
      start_job(8'h02, 2'b10, 12'd0, 12'd5);
      serve(0, 1, 1'b1, 300, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_done got=timeout exp=done"); end
      checks++; if (got_q.size() - gb != 5) begin
         failures++; $display("[TB] FAIL bp_words got=%0d exp=5", got_q.size() - gb); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (got_q[gb+i] !== 32'hA0 + 32'(i)) begin
            failures++; $display("[TB] FAIL bp_m_data[%0d] got=%h exp=%h", i, got_q[gb+i], 32'hA0 + 32'(i)); end
      end
      checks++; if (max_ahead > 2) begin
         failures++; $display("[TB] FAIL bp_reads_ahead got=%0d exp<=2", max_ahead); end
   endtask

   task automatic test_bad_length();
      int base = log_q.size();
      int dn0 = done_cnt;
      bit ok;
      start_job(8'h05, 2'b11, 12'd2049, 12'd0);
      checks++; if ({done, busy} !== 2'b10) begin
         failures++; $display("[TB] FAIL badlen_done_busy got=%b exp=10", {done, busy}); end
      serve(0, -1, 1'b0, 10, ok);
      checks++; if (!ok || (done_cnt != dn0 + 1)) begin
         failures++; $display("[TB] FAIL badlen_pulse got=%0d exp=1", done_cnt - dn0); end
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL badlen_err got=%b exp=1", err); end
      start_job(8'h05, 2'b11, 12'd0, 12'd2049);
      serve(0, -1, 1'b0, 10, ok);
      checks++; if (!ok || (err !== 1'b1)) begin
         failures++; $display("[TB] FAIL badlen_rd got=%b/%b exp=1/1", ok, err); end
      checks++; if (log_q.size() != base) begin
         failures++; $display("[TB] FAIL badlen_bus got=%0d exp=0", log_q.size() - base); end
   endtask

   task automatic test_stale_int();
      int base = log_q.size();
      bit ok;
      int_cal = 1'b1;
      start_job(8'h07, 2'b01, 12'd0, 12'd0);
      checks++; if ({busy, err, t_rden} !== 3'b101) begin
         failures++; $display("[TB] FAIL stale_start got=%b exp=101", {busy, err, t_rden}); end
      serve(0, 3, 1'b0, 200, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL stale_done got=timeout exp=done"); end
      checks++; if ((log_q[base].wr !== 1'b0) || (log_q[base].addr !== 14'h200C) ||
                    (log_q[base+1].wr !== 1'b1) || (log_q[base+1].addr !== 14'h2004)) begin
         failures++; $display("[TB] FAIL stale_order got=%0b/%h,%0b/%h exp=0/200c,1/2004",
                              log_q[base].wr, log_q[base].addr, log_q[base+1].wr, log_q[base+1].addr); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL stale_err got=%b exp=0", err); end
   endtask

   task automatic test_cpl_fail();
      int u0 = unl_rd;
      bit ok;
      cpl_val = 32'd0;
      start_job(8'h03, 2'b00, 12'd0, 12'd2);
      serve(0, 2, 1'b0, 200, ok);
      cpl_val = 32'd1;
      checks++; if (!ok || (err !== 1'b1)) begin
         failures++; $display("[TB] FAIL cplfail_err got=%b/%b exp=1/1", ok, err); end
      checks++; if (unl_rd != u0) begin
         failures++; $display("[TB] FAIL cplfail_unload got=%0d exp=0", unl_rd - u0); end
   endtask

`ifdef APU_HOST_TIMEOUT_EN
   task automatic test_timeout();
      int base = log_q.size();
      int u0 = unl_rd;
      bit ok;
      start_job(8'h04, 2'b00, 12'd0, 12'd2);
      serve(0, -1, 1'b0, 600, ok);
      checks++; if (!ok || (err !== 1'b1)) begin
         failures++; $display("[TB] FAIL timeout_err got=%b/%b exp=1/1", ok, err); end
      checks++; if ((log_q.size() - base != 4) || (log_q[base+3].addr !== 14'h200C) || (unl_rd != u0)) begin
         failures++; $display("[TB] FAIL timeout_bus got=%0d/%h exp=4/200c", log_q.size() - base, log_q[base+3].addr); end
   endtask
`endif

   task automatic test_reset_mid_job();
      int dn0 = done_cnt;
      start_job(8'h09, 2'b01, 12'd6, 12'd0);
      s_valid = 1'b1; s_data = 32'h1234_5678;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if ({s_ready, t_wren} !== 2'b11) begin
         failures++; $display("[TB] FAIL midrst_in_load got=%b exp=11", {s_ready, t_wren}); end
      rstn = 1'b0;
      #1;
      checks++; if ({busy, done, err, s_ready, m_valid, t_wren, t_rden} !== 7'b0 ||
                    {t_waddr, t_raddr, t_wdata} !== '0) begin
         failures++; $display("[TB] FAIL midrst_outputs got=%b/%h exp=0/0",
                              {busy, done, err, s_ready, m_valid, t_wren, t_rden}, {t_waddr, t_wdata}); end
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1; s_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++; if ((done_cnt != dn0) || (busy !== 1'b0)) begin
         failures++; $display("[TB] FAIL midrst_no_done got=%0d/%b exp=0/0", done_cnt - dn0, busy); end
   endtask

   task automatic test_bus_rules();
      checks++; if (both_cnt != 0) begin failures++; $display("[TB] FAIL bus_both_strobes got=%0d exp=0", both_cnt); end
      checks++; if (stray_cnt != 0) begin failures++; $display("[TB] FAIL bus_idle_nonzero got=%0d exp=0", stray_cnt); end
   endtask

   initial begin
      $display("[TB] starting apu_host_seq bench");
      test_reset();
      test_load_job();
      test_unload_stream();
      test_back_to_back();
      test_bad_length();
      test_stale_int();
      test_cpl_fail();
`ifdef APU_HOST_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_job();
      test_bus_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apu_host_seq.md
Name: apu_host_seq

Overview:
- Bus initiator that drives the APU register/RAM target bus (t_waddr/t_raddr/t_wren/t_rden/t_wdata/t_rdata) from the host side.
- On one start command it performs a full job:
  - loads an input word stream into APU RAM;
  - programs RAM select and control, then kicks the APU;
  - waits for the completion interrupt and acknowledges it;
  - streams result words back out.
- Sits between the host DMA streams and the APU address-map target.

Parameters:
- T_ADDR_WID, 14, target bus address width.
- LEN_WID, 12, width of the length fields; legal lengths are 0..2048 words.
- TMO_WID, 20, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_sel  in  8  value written to RAM_SEL (0x2004).
- cfg_ctrl  in  2  value written to RAM_CTRL (0x2000).
- cfg_wr_len  in  LEN_WID  words to load.
- cfg_rd_len  in  LEN_WID  words to unload.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  error status of the last job; held until the next accepted start.
- s_valid / s_ready / s_data  in / out / in  1/1/32  input word stream.
- m_valid / m_ready / m_data  out / in / out  1/1/32  result word stream.
- t_waddr  out  T_ADDR_WID;  t_raddr  out  T_ADDR_WID;  t_wren  out  1;  t_rden  out  1;  t_wdata  out  32;  t_rdata  in  32.
- int_cal  in  1  level completion interrupt from the target.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; read buffer empty. Reset mid-job abandons the job silently: no done pulse, no bus strobes.
- Bus rules:
  - t_wren and t_rden are never high in the same cycle.
  - Addresses and wdata are 0 whenever their strobe is low.
  - Read data is valid on t_rdata exactly 1 cycle after t_rden.
  - RAM word i uses byte address {i[10:0], 2'b00}.
- FSM states: IDLE, CLR, WR_SEL, WR_CTRL, LOAD, KICK, WAIT_INT, RD_CPL, CHK_CPL, UNLOAD, FIN.
  - IDLE, start=1:
    - If cfg_wr_len > 2048 or cfg_rd_len > 2048: no bus activity; err=1; done pulses the next cycle.
    - Else: err cleared, busy=1; go to CLR if int_cal=1 (stale interrupt), otherwise to WR_SEL.
  - CLR: one read of 0x200C; then WR_SEL.
  - WR_SEL: one write to 0x2004 with data {24'b0, cfg_sel}.
  - WR_CTRL: one write to 0x2000 with data {30'b0, cfg_ctrl}.
  - All cfg_* fields are latched at start; later changes have no effect.
- LOAD:
  - s_ready=1 for the whole state.
  - Each s_valid cycle issues t_wren to word index k with t_wdata=s_data; k counts 0..wr_len-1.
  - Leave LOAD after the last word. wr_len=0 skips LOAD.
- KICK: one write to 0x2008 with data 1.
- WAIT_INT: wait for int_cal=1, sampled in this state.
- RD_CPL: read 0x200C; this also clears the target interrupt.
- CHK_CPL:
  - t_rdata[0]=1: go to UNLOAD, or to FIN if rd_len=0.
  - Otherwise: err=1, go to FIN.
- UNLOAD:
  - Issue reads to words 0..rd_len-1.
  - A read is issued only when buffer occupancy + outstanding reads < 2.
  - Returned t_rdata is pushed into the 2-entry buffer the next cycle.
  - m_valid = buffer non-empty; m_data = buffer head.
  - Sustains 1 word/cycle while m_ready=1.
  - Leave UNLOAD when every word has been issued and the buffer has drained.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- start while busy is ignored.
- int_cal asserting outside WAIT_INT/CLR has no effect.
- Counters are LEN_WID+1 bits; index wrap past 2047 cannot occur because lengths are capped at 2048.

Optional Feature:
- APU_HOST_TIMEOUT_EN defined:
  - A TMO_WID counter runs in WAIT_INT and resets on state entry.
  - On reaching all-ones: err=1, go to CLR-style read of 0x200C, then FIN with no unload.
- Undefined: WAIT_INT waits indefinitely; no counter logic is present.

Decomposition:
- Package apu_host_pkg:
  - Address constants RAM_CTRL_ADDR=14'h2000, RAM_SEL_ADDR=14'h2004, APU_READY_ADDR=14'h2008, CPL_ADDR=14'h200C, MAX_WORDS=2048.
  - The FSM state enum typedef.
- Sub-module apu_host_rdbuf: 2-entry 32-bit FIFO with push, pop and count outputs, used by UNLOAD.

Test Plan:
- cfg_sel=8'h05, cfg_ctrl=2'b11, wr_len=4, rd_len=0; int_cal rises 10 cycles after KICK -> expected bus sequence:
  - W 0x2004=5; W 0x2000=3; W 0x0/0x4/0x8/0xC;
  - W 0x2008=1; R 0x200C returning 1;
  - done pulses once, err=0.
- wr_len=0, rd_len=3, t_rdata model returns 0xA0+i, m_ready=1 -> reads of 0x0, 0x4, 0x8 back-to-back; m_data=A0, A1, A2 on consecutive cycles.
- Same setup with m_ready toggled 1,0,0,1,... -> no word dropped or duplicated; at most 2 reads ahead of the consumer.
- start with cfg_wr_len=2049 -> no t_wren/t_rden; err=1; done pulses.
- int_cal=1 when start arrives -> first bus access is R 0x200C, before W 0x2004.
- CHK_CPL read returns 0 -> err=1, no UNLOAD reads. With APU_HOST_TIMEOUT_EN and int_cal held 0 -> timeout sets err and done. rstn pulsed during LOAD -> all outputs 0 immediately, no done.
